// File: rtl/frame_strobe_sequencer.sv
// Frame strobe sequencer: accepts (column, frame) write commands and walks
// each one through SETUP / STROBE / HOLD, driving a one-hot-or-zero strobe
// bus per column plus a one-cycle data-latch pulse ahead of the strobe.
module frame_strobe_sequencer #(
  parameter int unsigned MaxFramesPerCol  = 20,
  parameter int unsigned NumColumns       = 4,
  parameter int unsigned ColSelectWidth   = 2,
  parameter int unsigned FrameSelectWidth = 5,
  parameter int unsigned SetupCycles      = 1,
  parameter int unsigned StrobeCycles     = 2,
  parameter int unsigned HoldCycles       = 1
) (
  input  logic                                   UserCLK,
  input  logic                                   reset,
  input  logic                                   cmd_valid,
  output logic                                   cmd_ready,
  input  logic [ColSelectWidth-1:0]              cmd_col,
  input  logic [FrameSelectWidth-1:0]            cmd_frame,
  output logic                                   FrameDataLatch,
  output logic [NumColumns*MaxFramesPerCol-1:0]  FrameStrobe,
  output logic                                   busy,
  output logic                                   addr_err,
  output logic [15:0]                            frames_written
);

  localparam int unsigned StrobeWidth = NumColumns * MaxFramesPerCol;

  typedef enum logic [2:0] {
    IDLE,
    ERR,
    SETUP,
    STROBE,
    HOLD
  } state_t;

  state_t                        state_q, state_n;
  logic [3:0]                    cnt_q, cnt_n;
  logic [ColSelectWidth-1:0]     col_q, col_n;
  logic [FrameSelectWidth-1:0]   frame_q, frame_n;
  logic [15:0]                   fw_n;
  logic                          latch_n;
  logic [StrobeWidth-1:0]        strobe_n;
  int unsigned                   strobe_idx;

  // Next-state, phase counter and next output values; every output is
  // derived from the next state so the registered copy lines up with it.
  always_comb begin
    state_n    = state_q;
    cnt_n      = cnt_q;
    col_n      = col_q;
    frame_n    = frame_q;
    fw_n       = frames_written;
    latch_n    = 1'b0;
    strobe_n   = '0;
    strobe_idx = 0;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          col_n   = cmd_col;
          frame_n = cmd_frame;
          if (32'(cmd_frame) >= MaxFramesPerCol || 32'(cmd_col) >= NumColumns) begin
            state_n = ERR;
          end else begin
            state_n = SETUP;
            cnt_n   = 4'(SetupCycles - 1);
            latch_n = 1'b1;
          end
        end
      end
      ERR: begin
        state_n = IDLE;
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_n = STROBE;
          cnt_n   = 4'(StrobeCycles - 1);
        end else begin
          cnt_n = cnt_q - 4'd1;
        end
      end
      STROBE: begin
        if (cnt_q == '0) begin
          state_n = HOLD;
          cnt_n   = 4'(HoldCycles - 1);
          if (frames_written != '1) begin
            fw_n = frames_written + 16'd1;
          end
        end else begin
          cnt_n = cnt_q - 4'd1;
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt_q - 4'd1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    strobe_idx = 32'(col_n) * MaxFramesPerCol + 32'(frame_n);
    if (state_n == STROBE) begin
      for (int unsigned i = 0; i < StrobeWidth; i++) begin
        strobe_n[i] = (i == strobe_idx);
      end
    end
  end

  // State, command and output registers; reset forces every output idle.
  always_ff @(posedge UserCLK) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      col_q          <= '0;
      frame_q        <= '0;
      cmd_ready      <= 1'b1;
      busy           <= 1'b0;
      FrameDataLatch <= 1'b0;
      FrameStrobe    <= '0;
      addr_err       <= 1'b0;
      frames_written <= '0;
    end else begin
      state_q        <= state_n;
      cnt_q          <= cnt_n;
      col_q          <= col_n;
      frame_q        <= frame_n;
      cmd_ready      <= (state_n == IDLE);
      busy           <= (state_n != IDLE);
      FrameDataLatch <= latch_n;
      FrameStrobe    <= strobe_n;
      addr_err       <= (state_n == ERR);
      frames_written <= fw_n;
    end
  end

endmodule

// File: tb/tb_frame_strobe_sequencer.sv
// Directed bench for frame_strobe_sequencer: per-cycle vector table plus
// hand-written reset, alternate-timing and saturation sequences.
module tb_frame_strobe_sequencer;

  logic        clk;
  logic        reset;
  logic        cmd_valid, cmd_ready, latch, busy, addr_err;
  logic [1:0]  cmd_col;
  logic [4:0]  cmd_frame;
  logic [79:0] strobe;
  logic [15:0] fw;

  logic        v2, ready2, latch2, busy2, err2;
  logic [1:0]  c2;
  logic [4:0]  f2;
  logic [79:0] strobe2;
  logic [15:0] fw2;

  int pass_cnt = 0;
  int total_cnt = 0;

  frame_strobe_sequencer dut (
    .UserCLK(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_col(cmd_col), .cmd_frame(cmd_frame), .FrameDataLatch(latch),
    .FrameStrobe(strobe), .busy(busy), .addr_err(addr_err), .frames_written(fw)
  );

  frame_strobe_sequencer #(
    .SetupCycles(3), .StrobeCycles(1), .HoldCycles(2)
  ) dut2 (
    .UserCLK(clk), .reset(reset), .cmd_valid(v2), .cmd_ready(ready2),
    .cmd_col(c2), .cmd_frame(f2), .FrameDataLatch(latch2),
    .FrameStrobe(strobe2), .busy(busy2), .addr_err(err2), .frames_written(fw2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [1:0]  col;
    logic [4:0]  frame;
    logic        ready;
    logic        latch;
    int          sbit;
    logic        err;
    logic [15:0] fw;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic chk_dut1(input string tag, input logic e_ready, input logic e_latch,
                          input int e_sbit, input logic e_err, input logic [15:0] e_fw);
    logic [79:0] e_strobe;
    e_strobe = '0;
    if (e_sbit >= 0) e_strobe[e_sbit] = 1'b1;
    chk({tag, ".ready"},  80'(cmd_ready), 80'(e_ready));
    chk({tag, ".busy"},   80'(busy),      80'(!e_ready));
    chk({tag, ".latch"},  80'(latch),     80'(e_latch));
    chk({tag, ".strobe"}, strobe,         e_strobe);
    chk({tag, ".err"},    80'(addr_err),  80'(e_err));
    chk({tag, ".fw"},     80'(fw),        80'(e_fw));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One accepted command, returning in the first IDLE cycle afterwards.
  task automatic run_cmd(input logic [1:0] c, input logic [4:0] f);
    cmd_valid = 1'b1; cmd_col = c; cmd_frame = f;
    tick;
    cmd_valid = 1'b0;
    repeat (4) tick;
  endtask

  initial begin
    // Record i: inputs driven before edge i, outputs expected in cycle i+1.
    tbl[0]  = '{1'b1, 2'd1, 5'd5,  1'b0, 1'b1, -1, 1'b0, 16'd0};
    tbl[1]  = '{1'b0, 2'd0, 5'd0,  1'b0, 1'b0, 25, 1'b0, 16'd0};
    tbl[2]  = '{1'b0, 2'd0, 5'd0,  1'b0, 1'b0, 25, 1'b0, 16'd0};
    tbl[3]  = '{1'b0, 2'd0, 5'd0,  1'b0, 1'b0, -1, 1'b0, 16'd1};
    tbl[4]  = '{1'b0, 2'd0, 5'd0,  1'b1, 1'b0, -1, 1'b0, 16'd1};
    tbl[5]  = '{1'b1, 2'd0, 5'd0,  1'b0, 1'b1, -1, 1'b0, 16'd1};
    tbl[6]  = '{1'b1, 2'd3, 5'd19, 1'b0, 1'b0, 0,  1'b0, 16'd1};
    tbl[7]  = '{1'b1, 2'd3, 5'd19, 1'b0, 1'b0, 0,  1'b0, 16'd1};
    tbl[8]  = '{1'b1, 2'd3, 5'd19, 1'b0, 1'b0, -1, 1'b0, 16'd2};
    tbl[9]  = '{1'b1, 2'd3, 5'd19, 1'b1, 1'b0, -1, 1'b0, 16'd2};
    tbl[10] = '{1'b1, 2'd3, 5'd19, 1'b0, 1'b1, -1, 1'b0, 16'd2};
    tbl[11] = '{1'b0, 2'd0, 5'd0,  1'b0, 1'b0, 79, 1'b0, 16'd2};
    tbl[12] = '{1'b0, 2'd0, 5'd0,  1'b0, 1'b0, 79, 1'b0, 16'd2};
    tbl[13] = '{1'b0, 2'd0, 5'd0,  1'b0, 1'b0, -1, 1'b0, 16'd3};
    tbl[14] = '{1'b0, 2'd0, 5'd0,  1'b1, 1'b0, -1, 1'b0, 16'd3};
    tbl[15] = '{1'b1, 2'd0, 5'd20, 1'b0, 1'b0, -1, 1'b1, 16'd3};
    tbl[16] = '{1'b0, 2'd0, 5'd0,  1'b1, 1'b0, -1, 1'b0, 16'd3};

    reset = 1'b1; cmd_valid = 1'b0; cmd_col = '0; cmd_frame = '0;
    v2 = 1'b0; c2 = '0; f2 = '0;
    tick; tick;
    chk_dut1("reset", 1'b1, 1'b0, -1, 1'b0, 16'd0);
    reset = 1'b0;
    tick;

    for (int i = 0; i < 17; i++) begin
      cmd_valid = tbl[i].valid; cmd_col = tbl[i].col; cmd_frame = tbl[i].frame;
      tick;
      chk_dut1($sformatf("vec%0d", i), tbl[i].ready, tbl[i].latch,
               tbl[i].sbit, tbl[i].err, tbl[i].fw);
    end
    cmd_valid = 1'b0;

    // Reset sampled during the first STROBE cycle.
    cmd_valid = 1'b1; cmd_col = 2'd2; cmd_frame = 5'd3;
    tick;
    cmd_valid = 1'b0;
    tick;
    chk_dut1("rst_mid.pre", 1'b0, 1'b0, 43, 1'b0, 16'd3);
    reset = 1'b1;
    tick;
    chk_dut1("rst_mid.post", 1'b1, 1'b0, -1, 1'b0, 16'd0);
    reset = 1'b0;
    tick;
    chk_dut1("rst_mid.idle", 1'b1, 1'b0, -1, 1'b0, 16'd0);
    run_cmd(2'd2, 5'd3);
    chk_dut1("rst_mid.after", 1'b1, 1'b0, -1, 1'b0, 16'd1);

    // Alternate timing: Setup=3, Strobe=1, Hold=2.
    v2 = 1'b1; c2 = 2'd2; f2 = 5'd7;
    tick;
    v2 = 1'b0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      logic [79:0] e_s;
      e_s = '0;
      if (cyc == 4) e_s[47] = 1'b1;
      chk($sformatf("alt%0d.latch", cyc),  80'(latch2), 80'(cyc == 1));
      chk($sformatf("alt%0d.strobe", cyc), strobe2,     e_s);
      chk($sformatf("alt%0d.ready", cyc),  80'(ready2), 80'(cyc >= 7));
      if (cyc < 8) tick;
    end
    chk("alt.fw", 80'(fw2), 80'd1);

    // Saturation of frames_written near the top of its range.
    @(negedge clk);
    force dut.frames_written = 16'hFFFE;
    @(posedge clk);
    @(negedge clk);
    release dut.frames_written;
    #1;
    chk("sat.preload", 80'(fw), 80'hFFFE);
    run_cmd(2'd1, 5'd1);
    chk("sat.reach", 80'(fw), 80'hFFFF);
    run_cmd(2'd0, 5'd19);
    chk("sat.hold", 80'(fw), 80'hFFFF);
    chk("sat.ready", 80'(cmd_ready), 80'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/frame_strobe_sequencer.md
# frame_strobe_sequencer

Configuration-side controller that drives the per-column `FrameStrobe` buses of the fabric, which the tiles buffer and pass northward.
- Accepts frame-write commands (column, frame index) over a valid/ready handshake.
- Sequences each command through setup, strobe and hold phases, emitting a one-cycle `FrameDataLatch` pulse to the frame data register before the strobe.
- Exactly one strobe line is active at a time, and never outside the STROBE phase.
- Sits between the bitstream loader and the column `FrameStrobe` inputs of the bottom terminal tiles.

## Interface
Parameters:
- `MaxFramesPerCol`, 20, strobe lines per column.
- `NumColumns`, 4, number of fabric columns driven.
- `ColSelectWidth`, 2, width of `cmd_col`.
- `FrameSelectWidth`, 5, width of `cmd_frame`.
- `SetupCycles`, 1, cycles in SETUP (legal range 1..15).
- `StrobeCycles`, 2, cycles strobe is held high (legal range 1..15).
- `HoldCycles`, 1, all-zero cycles after the strobe (legal range 1..15).

Ports:
- `UserCLK`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command.
- `cmd_col`  in  ColSelectWidth  target column.
- `cmd_frame`  in  FrameSelectWidth  target frame within the column.
- `FrameDataLatch`  out  1  one-cycle pulse telling the frame data register to capture.
- `FrameStrobe`  out  NumColumns*MaxFramesPerCol  one-hot-or-zero strobe bus; column c occupies bits [c*MaxFramesPerCol +: MaxFramesPerCol].
- `busy`  out  1  high whenever state is not IDLE.
- `addr_err`  out  1  one-cycle pulse for a rejected command.
- `frames_written`  out  16  count of completed strobes, saturating.

## Operation
- FSM states: IDLE, ERR, SETUP, STROBE, HOLD. All outputs are registered.
- Reset values:
  - state IDLE, `cmd_ready`=1, `busy`=0.
  - `FrameDataLatch`=0, `FrameStrobe`=0, `addr_err`=0, `frames_written`=0.
- IDLE:
  - `cmd_ready`=1.
  - Handshake: a command is accepted when `cmd_valid`=1 and `cmd_ready`=1 at a rising edge. `cmd_col` and `cmd_frame` are registered at that edge.
- Address check on accept:
  - If `cmd_frame` >= MaxFramesPerCol or `cmd_col` >= NumColumns, go to ERR.
  - Otherwise go to SETUP and load the phase counter with SetupCycles-1.
- ERR:
  - Lasts exactly 1 cycle with `addr_err`=1 and `cmd_ready`=0.
  - Then IDLE.
  - No strobe, no latch pulse, counter unchanged.
- SETUP:
  - `FrameDataLatch`=1 in the first SETUP cycle only.
  - When the phase counter reaches 0, go to STROBE with the counter loaded to StrobeCycles-1.
- STROBE:
  - Bit index = col*MaxFramesPerCol + frame is high; all other bits are 0.
  - When the counter reaches 0, go to HOLD with the counter loaded to HoldCycles-1, and increment `frames_written`.
- HOLD:
  - `FrameStrobe`=0.
  - When the counter reaches 0, go to IDLE.
- `frames_written`: 16-bit, saturates at 0xFFFF and does not wrap.
- `cmd_valid` while not IDLE: ignored (`cmd_ready`=0); the command is not lost on the requester side.
- Reset mid-operation: at the reset edge all outputs take their reset values.
  - `FrameStrobe` is 0 in the cycle after reset is sampled, regardless of state.
  - The in-flight command is dropped and not counted.

## Timing
- Accept at edge k; default parameters:
  - `FrameDataLatch` high in cycle k+1.
  - `FrameStrobe` high in cycles k+2 and k+3.
  - HOLD in cycle k+4.
  - `cmd_ready`=1 from cycle k+5.
- General case:
  - Latch in cycle k+1.
  - Strobe in cycles k+1+SetupCycles through k+SetupCycles+StrobeCycles.
  - `cmd_ready` returns in cycle k+1+SetupCycles+StrobeCycles+HoldCycles.
  - Back-to-back throughput: one frame per SetupCycles+StrobeCycles+HoldCycles+1 cycles.
- `frames_written` reflects the increment in the first HOLD cycle.
- Rejected command: `addr_err` high in cycle k+1; `cmd_ready` high in cycle k+2.
- `busy` = !`cmd_ready` in every cycle.

## Test plan
- Reset, then col=1, frame=5 accepted at edge 0 (defaults):
  - latch in cycle 1; `FrameStrobe`[25]=1 in cycles 2-3, all other bits 0.
  - `frames_written`=1 in cycle 4; `cmd_ready`=1 in cycle 5.
- Back-to-back with `cmd_valid` held high, commands (0,0) then (3,19):
  - second accept at edge 5; `FrameStrobe`[79] high in cycles 7-8.
  - never two strobe bits high in the same cycle.
- col=0, frame=20 (out of range):
  - `addr_err` high for exactly cycle 1; no latch, no strobe.
  - `frames_written` unchanged; `cmd_ready` high in cycle 2.
- `reset` asserted during cycle 2 (STROBE):
  - cycle 3 has `FrameStrobe`=0, state IDLE, `frames_written`=0.
- `frames_written` preloaded to 0xFFFF via 65535 commands, or forced in the bench; one more valid command:
  - counter stays 0xFFFF.
- SetupCycles=3, StrobeCycles=1, HoldCycles=2, accept at edge 0:
  - latch in cycle 1 only; strobe in cycle 4 only; `cmd_ready` in cycle 7.
